jk_bank_sequencer: RTL and testbench
====================================

Name: jk_bank_sequencer

Overview:
- Command-driven controller for a bank of WIDTH JK flip-flops.
- Translates hold/set/reset/toggle commands into per-bit J/K drive and repeats each command for a programmed number of clock cycles.
- Holds a shadow copy of the bank state (q), so the block is self-checking and can stand alone as a masked JK register.
- Sits between a command source (valid/ready) and the JK flop bank.

Parameters:
- WIDTH, 4, number of JK bits in the bank.
- CNT_W, 4, width of the repeat-count field; max repeats 2^CNT_W-1.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- clear  input  1  asynchronous, active-high reset.
- cmd_valid  input  1  command request.
- cmd_ready  output  1  block can accept a command (high only in IDLE).
- cmd_op  input  2  00 hold, 01 set, 10 reset, 11 toggle.
- cmd_mask  input  WIDTH  bits affected; unmasked bits get j=k=0.
- cmd_count  input  CNT_W  number of APPLY cycles; 0 is treated as 1.
- abort  input  1  synchronous early-terminate request.
- j  output  WIDTH  J drive to the bank (combinational from state/op/mask/abort).
- k  output  WIDTH  K drive to the bank.
- q  output  WIDTH  shadow bank state.
- busy  output  1  high in APPLY and DONE.
- done  output  1  one-cycle pulse in DONE.
- aborted  output  1  valid with done; 1 if the command ended by abort.

Behaviour:
- Reset (clear=1, asynchronous):
  - state=IDLE, q=0, remaining=0.
  - Latched op/mask = 0.
  - done=0, aborted=0, busy=0, cmd_ready=0 while clear is asserted.
  - Reset takes effect mid-operation with no completion pulse.
- After clear deasserts, cmd_ready=1 (IDLE). The first edge with clear=0 can accept a command.
- IDLE:
  - j=k=0, cmd_ready=1.
  - On an edge with cmd_valid=1: latch op and mask; remaining = (cmd_count==0) ? 1 : cmd_count; go to APPLY.
  - cmd_valid=0 keeps the block in IDLE.
- APPLY:
  - cmd_ready=0, busy=1.
  - When abort=0, per masked bit i:
    - set: j=1, k=0
    - reset: j=0, k=1
    - toggle: j=1, k=1
    - hold: j=0, k=0
  - Unmasked bits always get j=k=0.
  - At each edge: q[i] <= (j&~k) ? 1 : (~j&k) ? 0 : (j&k) ? ~q[i] : q[i]; remaining decrements.
  - remaining==1 at an edge goes to DONE; otherwise the block stays in APPLY.
- abort in APPLY:
  - j=k=0 combinationally in that cycle, so q holds.
  - Next state is DONE with aborted=1.
  - abort outside APPLY is ignored.
- DONE:
  - done=1 and busy=1 for exactly one cycle; cmd_ready=0, j=k=0.
  - Unconditionally returns to IDLE. aborted clears on leaving DONE.
- Latency: command accepted at edge E0; APPLY edges E1..EN; done visible in the cycle after EN. Back-to-back commands are possible every N+2 cycles.
- cmd_valid while busy is ignored. No queuing; the source must hold cmd_valid until it sees cmd_ready.
- Shadow q must equal the state of a JK flop bank driven by j/k on the same clk.
- Count arithmetic is unsigned CNT_W-bit with no wrap: remaining never decrements below 1 in APPLY.

Test Plan:
- Reset: assert clear mid-cycle with random inputs -> q=0000, busy=0, done=0 immediately (asynchronous). After release, cmd_ready=1.
- Set: op=01, mask=0101, count=1 from q=0000 -> j=0101, k=0000 for one cycle; q=0101; done pulse 2 cycles after acceptance; aborted=0.
- Toggle repeat: from q=0101, op=11, mask=1111, count=3 -> q sequence 1010, 0101, 1010; done one cycle after the 3rd APPLY edge; final q=1010.
- Count zero and mask: op=10, mask=0011, count=0 from q=1111 -> exactly one APPLY cycle with k=0011, j=0000; q=1100.
- Abort: op=11, mask=1111, count=5 from q=0000; abort during the 3rd APPLY cycle -> q=0000 (two toggles, third suppressed); done=1, aborted=1 next cycle.
- Busy ignore and reset mid-operation:
  - cmd_valid held with a different op during APPLY -> not accepted until the next IDLE.
  - clear pulsed during APPLY -> q=0, state IDLE, no done pulse.

Source files
------------

// File: rtl/jk_bank_sequencer_if.sv
// Command/drive bundle between a command source and jk_bank_sequencer.
// The master side issues commands. The slave side is the sequencer, which drives the JK bank.
interface jk_bank_sequencer_if #(
  parameter int unsigned WIDTH = 4,
  parameter int unsigned CNT_W = 4
);
  logic             cmd_valid;
  logic             cmd_ready;
  logic [1:0]       cmd_op;
  logic [WIDTH-1:0] cmd_mask;
  logic [CNT_W-1:0] cmd_count;
  logic             abort;
  logic [WIDTH-1:0] j;
  logic [WIDTH-1:0] k;
  logic [WIDTH-1:0] q;
  logic             busy;
  logic             done;
  logic             aborted;

  modport master (
    output cmd_valid, cmd_op, cmd_mask, cmd_count, abort,
    input  cmd_ready, j, k, q, busy, done, aborted
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_mask, cmd_count, abort,
    output cmd_ready, j, k, q, busy, done, aborted
  );
endinterface

// File: rtl/jk_bank_sequencer.sv
// Command-driven sequencer for a bank of JK flops.
// It repeats a masked hold/set/reset/toggle command for a programmed number of cycles and keeps a shadow copy of the bank state.
module jk_bank_sequencer #(
  parameter int unsigned WIDTH = 4,
  parameter int unsigned CNT_W = 4
) (
  input logic                  clk,
  input logic                  clear,
  jk_bank_sequencer_if.slave   bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    APPLY = 2'd1,
    DONE  = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    OP_HOLD   = 2'b00,
    OP_SET    = 2'b01,
    OP_RESET  = 2'b10,
    OP_TOGGLE = 2'b11
  } op_t;

  state_t           state;
  op_t              op_r;
  logic [WIDTH-1:0] mask_r;
  logic [CNT_W-1:0] remaining;
  logic [WIDTH-1:0] q_r;
  logic             busy_r;
  logic             done_r;
  logic             aborted_r;

  logic [WIDTH-1:0] j_drv;
  logic [WIDTH-1:0] k_drv;
  logic [WIDTH-1:0] q_next;

  // Abort gates the drive in the same cycle, so the bank holds on the abort edge.
  always_comb begin
    j_drv = '0;
    k_drv = '0;
    if (state == APPLY && !bus.abort) begin
      unique case (op_r)
        OP_SET:    j_drv = mask_r;
        OP_RESET:  k_drv = mask_r;
        OP_TOGGLE: begin
          j_drv = mask_r;
          k_drv = mask_r;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    q_next = q_r;
    for (int unsigned i = 0; i < WIDTH; i++) begin
      unique case ({j_drv[i], k_drv[i]})
        2'b10:   q_next[i] = 1'b1;
        2'b01:   q_next[i] = 1'b0;
        2'b11:   q_next[i] = ~q_r[i];
        default: q_next[i] = q_r[i];
      endcase
    end
  end

  always_ff @(posedge clk or posedge clear) begin
    if (clear) begin
      state     <= IDLE;
      op_r      <= OP_HOLD;
      mask_r    <= '0;
      remaining <= '0;
      q_r       <= '0;
      busy_r    <= 1'b0;
      done_r    <= 1'b0;
      aborted_r <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          done_r    <= 1'b0;
          aborted_r <= 1'b0;
          if (bus.cmd_valid) begin
            op_r      <= op_t'(bus.cmd_op);
            mask_r    <= bus.cmd_mask;
            remaining <= (bus.cmd_count == '0) ? CNT_W'(1) : bus.cmd_count;
            busy_r    <= 1'b1;
            state     <= APPLY;
          end
        end
        APPLY: begin
          q_r <= q_next;
          if (bus.abort) begin
            done_r    <= 1'b1;
            aborted_r <= 1'b1;
            state     <= DONE;
          end else if (remaining == CNT_W'(1)) begin
            done_r <= 1'b1;
            state  <= DONE;
          end else begin
            remaining <= remaining - CNT_W'(1);
          end
        end
        DONE: begin
          done_r    <= 1'b0;
          aborted_r <= 1'b0;
          busy_r    <= 1'b0;
          state     <= IDLE;
        end
        default: begin
          busy_r <= 1'b0;
          done_r <= 1'b0;
          state  <= IDLE;
        end
      endcase
    end
  end

  assign bus.cmd_ready = (state == IDLE) && !clear;
  assign bus.j         = j_drv;
  assign bus.k         = k_drv;
  assign bus.q         = q_r;
  assign bus.busy      = busy_r;
  assign bus.done      = done_r;
  assign bus.aborted   = aborted_r;

endmodule

// File: tb/tb_jk_bank_sequencer.sv
// Directed bench for jk_bank_sequencer: it applies hand-computed vectors and checks each one with an immediate assertion.
module tb_jk_bank_sequencer;

  logic clk;
  logic clear;
  int   checks;
  int   failures;

  jk_bank_sequencer_if #(.WIDTH(4), .CNT_W(4)) bus ();

  jk_bank_sequencer #(.WIDTH(4), .CNT_W(4)) dut (
    .clk   (clk),
    .clear (clear),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic cmd(input logic [1:0] op, input logic [3:0] mask, input logic [3:0] count);
    bus.cmd_valid = 1'b1;
    bus.cmd_op    = op;
    bus.cmd_mask  = mask;
    bus.cmd_count = count;
  endtask

  task automatic idle_inputs();
    bus.cmd_valid = 1'b0;
    bus.cmd_op    = 2'b00;
    bus.cmd_mask  = 4'b0000;
    bus.cmd_count = 4'd0;
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    clear    = 1'b0;
    bus.abort     = 1'($urandom);
    bus.cmd_valid = 1'($urandom);
    bus.cmd_op    = 2'($urandom);
    bus.cmd_mask  = 4'($urandom);
    bus.cmd_count = 4'($urandom);

    // Reset asserted mid-cycle; its effect is asynchronous
    #3 clear = 1'b1;
    #1;
    check("rst_q", 32'(bus.q), 32'h0);
    check("rst_busy", 32'(bus.busy), 32'h0);
    check("rst_done", 32'(bus.done), 32'h0);
    check("rst_ready", 32'(bus.cmd_ready), 32'h0);
    tick();
    tick();
    idle_inputs();
    bus.abort = 1'b0;
    clear = 1'b0;
    #1;
    check("rel_ready", 32'(bus.cmd_ready), 32'h1);
    check("rel_jk", 32'({bus.j, bus.k}), 32'h0);

    // Set: op=01, mask=0101, count=1
    cmd(2'b01, 4'b0101, 4'd1);
    tick();
    idle_inputs();
    check("set_ready", 32'(bus.cmd_ready), 32'h0);
    check("set_busy", 32'(bus.busy), 32'h1);
    check("set_j", 32'(bus.j), 32'h5);
    check("set_k", 32'(bus.k), 32'h0);
    check("set_done_early", 32'(bus.done), 32'h0);
    tick();
    check("set_q", 32'(bus.q), 32'h5);
    check("set_done", 32'(bus.done), 32'h1);
    check("set_aborted", 32'(bus.aborted), 32'h0);
    check("set_done_busy", 32'(bus.busy), 32'h1);
    check("set_done_jk", 32'({bus.j, bus.k}), 32'h0);
    tick();
    check("set_idle_done", 32'(bus.done), 32'h0);
    check("set_idle_busy", 32'(bus.busy), 32'h0);
    check("set_idle_ready", 32'(bus.cmd_ready), 32'h1);

    // Toggle repeat: op=11, mask=1111, count=3 starting from q=0101
    cmd(2'b11, 4'b1111, 4'd3);
    tick();
    idle_inputs();
    check("tog_j", 32'(bus.j), 32'hF);
    check("tog_k", 32'(bus.k), 32'hF);
    tick();
    check("tog_q1", 32'(bus.q), 32'hA);
    check("tog_done1", 32'(bus.done), 32'h0);
    tick();
    check("tog_q2", 32'(bus.q), 32'h5);
    check("tog_done2", 32'(bus.done), 32'h0);
    tick();
    check("tog_q3", 32'(bus.q), 32'hA);
    check("tog_done3", 32'(bus.done), 32'h1);
    check("tog_aborted", 32'(bus.aborted), 32'h0);
    tick();
    check("tog_end_q", 32'(bus.q), 32'hA);
    check("tog_end_ready", 32'(bus.cmd_ready), 32'h1);

    // Bring q to 1111: set mask=0101 from 1010
    cmd(2'b01, 4'b0101, 4'd1);
    tick();
    idle_inputs();
    tick();
    tick();
    check("pre_cz_q", 32'(bus.q), 32'hF);

    // Count zero: op=10, mask=0011, count=0 -> exactly one APPLY cycle
    cmd(2'b10, 4'b0011, 4'd0);
    tick();
    idle_inputs();
    check("cz_j", 32'(bus.j), 32'h0);
    check("cz_k", 32'(bus.k), 32'h3);
    tick();
    check("cz_q", 32'(bus.q), 32'hC);
    check("cz_done", 32'(bus.done), 32'h1);
    tick();
    check("cz_ready", 32'(bus.cmd_ready), 32'h1);

    // Clear q fully: op=10, mask=1111, count=1
    cmd(2'b10, 4'b1111, 4'd1);
    tick();
    idle_inputs();
    tick();
    tick();
    check("pre_ab_q", 32'(bus.q), 32'h0);

    // Abort during the 3rd APPLY cycle of toggle count=5
    cmd(2'b11, 4'b1111, 4'd5);
    tick();
    idle_inputs();
    tick();
    check("ab_q1", 32'(bus.q), 32'hF);
    tick();
    check("ab_q2", 32'(bus.q), 32'h0);
    bus.abort = 1'b1;
    #1;
    check("ab_jk_gated", 32'({bus.j, bus.k}), 32'h0);
    tick();
    bus.abort = 1'b0;
    check("ab_q_held", 32'(bus.q), 32'h0);
    check("ab_done", 32'(bus.done), 32'h1);
    check("ab_aborted", 32'(bus.aborted), 32'h1);
    tick();
    check("ab_aborted_clr", 32'(bus.aborted), 32'h0);
    check("ab_idle_done", 32'(bus.done), 32'h0);
    // Abort in IDLE is ignored
    bus.abort = 1'b1;
    tick();
    check("ab_idle_ignored", 32'(bus.cmd_ready), 32'h1);
    bus.abort = 1'b0;

    // Busy ignore: the second command is held on the bus while the first runs
    cmd(2'b01, 4'b1111, 4'd2);
    tick();
    cmd(2'b10, 4'b1111, 4'd1);
    check("bi_j", 32'(bus.j), 32'hF);
    tick();
    check("bi_q1", 32'(bus.q), 32'hF);
    check("bi_busy1", 32'(bus.busy), 32'h1);
    check("bi_k1", 32'(bus.k), 32'h0);
    tick();
    check("bi_q2", 32'(bus.q), 32'hF);
    check("bi_done", 32'(bus.done), 32'h1);
    tick();
    check("bi_idle_ready", 32'(bus.cmd_ready), 32'h1);
    check("bi_idle_q", 32'(bus.q), 32'hF);
    tick();
    idle_inputs();
    check("bi_acc_k", 32'(bus.k), 32'hF);
    check("bi_acc_j", 32'(bus.j), 32'h0);
    tick();
    check("bi_acc_q", 32'(bus.q), 32'h0);
    check("bi_acc_done", 32'(bus.done), 32'h1);
    tick();

    // Reset mid-operation: no completion pulse
    cmd(2'b01, 4'b1010, 4'd4);
    tick();
    idle_inputs();
    tick();
    check("rm_q1", 32'(bus.q), 32'hA);
    #2 clear = 1'b1;
    #1;
    check("rm_q", 32'(bus.q), 32'h0);
    check("rm_busy", 32'(bus.busy), 32'h0);
    check("rm_done", 32'(bus.done), 32'h0);
    tick();
    clear = 1'b0;
    #1;
    check("rm_ready", 32'(bus.cmd_ready), 32'h1);
    for (int i = 0; i < 4; i++) begin
      tick();
      check("rm_no_done", 32'(bus.done), 32'h0);
      check("rm_idle_q", 32'(bus.q), 32'h0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
